// File: rtl/mul_iter_unit_pkg.sv
// Shared core constants: multiply op encodings, iterative-unit state encodings,
// and the default datapath width used by the ALU/multiplier/divider family.
package mul_iter_unit_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;

  typedef enum logic [1:0] {
    MUL_OP_MUL    = 2'b00,
    MUL_OP_MULH   = 2'b01,
    MUL_OP_MULHSU = 2'b10,
    MUL_OP_MULHU  = 2'b11
  } mul_op_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_COMPUTE = 2'b01,
    ST_DONE    = 2'b10
  } iter_state_e;

  // Digit widths the shift-add datapath supports.
  function automatic bit bpc_legal(int unsigned bpc);
    return (bpc == 1) || (bpc == 2) || (bpc == 4) || (bpc == 8);
  endfunction

endpackage

// File: rtl/mul_iter_unit_step.sv
// One shift-add step: adds multiplicand * digit to the running product.
// Purely combinational; the digit is BITS_PER_CYCLE multiplier bits.
module mul_step
   import mul_iter_unit_pkg::*;
#(
   parameter int unsigned XLEN           = XLEN_DEFAULT,
   parameter int unsigned BITS_PER_CYCLE = 2
) (
   input  logic [2*XLEN-1:0]         product_i,
   input  logic [2*XLEN-1:0]         mcand_i,
   input  logic [BITS_PER_CYCLE-1:0] digit_i,
   output logic [2*XLEN-1:0]         product_o
);

   logic [2*XLEN-1:0] acc;

   // Accumulate one shifted partial product per set digit bit.
   always_comb begin
      acc = product_i;
      for (int unsigned i = 0; i < BITS_PER_CYCLE; i++) begin
         if (digit_i[i]) begin
            acc = acc + (mcand_i << i);
         end
      end
      product_o = acc;
   end

endmodule

// File: rtl/mul_iter_unit.sv
// Iterative shift-add multiplier for RV32M/RV64M MUL/MULH/MULHSU/MULHU/MULW.
// Operates on operand magnitudes and applies the sign to the full product.
module mul_iter_unit
   import mul_iter_unit_pkg::*;
#(
   parameter int unsigned XLEN           = XLEN_DEFAULT,
   parameter int unsigned BITS_PER_CYCLE = 2,
   parameter bit          EARLY_OUT      = 1'b1
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            start,
   input  logic            kill,
   input  logic [1:0]      mul_op,
   input  logic            is_word_op,
   input  logic [XLEN-1:0] operand_a,
   input  logic [XLEN-1:0] operand_b,
   output logic [XLEN-1:0] result,
   output logic            busy,
   output logic            ready
);

   localparam int unsigned PW     = 2 * XLEN;
   localparam int unsigned K_FULL = (XLEN + BITS_PER_CYCLE - 1) / BITS_PER_CYCLE;
   localparam int unsigned K_WORD = (32 + BITS_PER_CYCLE - 1) / BITS_PER_CYCLE;
   localparam int unsigned CW     = $clog2(K_FULL + 1);

   if (!bpc_legal(BITS_PER_CYCLE)) begin : g_bad_bpc
      $error("mul_iter_unit: BITS_PER_CYCLE must be 1, 2, 4 or 8");
   end
   if (!((XLEN == 32) || (XLEN == 64))) begin : g_bad_xlen
      $error("mul_iter_unit: XLEN must be 32 or 64");
   end

   iter_state_e       state_q, state_d;
   mul_op_e           op_q, op_d;
   logic              word_q, word_d;
   logic              neg_q, neg_d;
   logic [PW-1:0]     prod_q, prod_d;
   logic [PW-1:0]     mcand_q, mcand_d;
   logic [XLEN-1:0]   mplier_q, mplier_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [XLEN-1:0]   result_q, result_d;
   logic              ready_q, ready_d;

   logic              word_in, neg_a, neg_b;
   logic [XLEN-1:0]   mag_a, mag_b;
   logic [PW-1:0]     step_prod;
   logic [PW-1:0]     final_prod;
   logic [CW-1:0]     k_last;

   mul_step #(
      .XLEN          (XLEN),
      .BITS_PER_CYCLE(BITS_PER_CYCLE)
   ) u_step (
      .product_i(prod_q),
      .mcand_i  (mcand_q),
      .digit_i  (mplier_q[BITS_PER_CYCLE-1:0]),
      .product_o(step_prod)
   );

   // Operand conditioning: signedness by op, magnitudes, word-op zero extension.
   always_comb begin
      word_in = (XLEN == 64) && is_word_op;
      neg_a   = 1'b0;
      neg_b   = 1'b0;
      if (word_in) begin
         mag_a = XLEN'(operand_a[31:0]);
         mag_b = XLEN'(operand_b[31:0]);
      end else begin
         neg_a = ((mul_op == MUL_OP_MULH) || (mul_op == MUL_OP_MULHSU)) && operand_a[XLEN-1];
         neg_b = (mul_op == MUL_OP_MULH) && operand_b[XLEN-1];
         mag_a = neg_a ? -operand_a : operand_a;
         mag_b = neg_b ? -operand_b : operand_b;
      end
   end

   // Next state, datapath update and result selection; kill overrides all.
   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      word_d     = word_q;
      neg_d      = neg_q;
      prod_d     = prod_q;
      mcand_d    = mcand_q;
      mplier_d   = mplier_q;
      cnt_d      = cnt_q;
      result_d   = result_q;
      ready_d    = 1'b0;
      k_last     = word_q ? CW'(K_WORD - 1) : CW'(K_FULL - 1);
      final_prod = neg_q ? -prod_q : prod_q;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d  = ST_COMPUTE;
               op_d     = mul_op_e'(mul_op);
               word_d   = word_in;
               neg_d    = neg_a ^ neg_b;
               prod_d   = '0;
               mcand_d  = PW'(mag_a);
               mplier_d = mag_b;
               cnt_d    = '0;
            end
         end
         ST_COMPUTE: begin
            prod_d   = step_prod;
            mcand_d  = mcand_q << BITS_PER_CYCLE;
            mplier_d = mplier_q >> BITS_PER_CYCLE;
            cnt_d    = cnt_q + CW'(1);
            if ((cnt_q == k_last) || (EARLY_OUT && (mplier_d == '0))) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
            ready_d = 1'b1;
            if (word_q) begin
               result_d = XLEN'($signed(final_prod[31:0]));
            end else if (op_q == MUL_OP_MUL) begin
               result_d = final_prod[XLEN-1:0];
            end else begin
               result_d = final_prod[PW-1:XLEN];
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (kill) begin
         state_d  = ST_IDLE;
         ready_d  = 1'b0;
         result_d = result_q;
      end
   end

   // State and datapath registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q  <= ST_IDLE;
         op_q     <= MUL_OP_MUL;
         word_q   <= 1'b0;
         neg_q    <= 1'b0;
         prod_q   <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         cnt_q    <= '0;
         result_q <= '0;
         ready_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         word_q   <= word_d;
         neg_q    <= neg_d;
         prod_q   <= prod_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
         ready_q  <= ready_d;
      end
   end

   assign busy   = (state_q != ST_IDLE);
   assign ready  = ready_q;
   assign result = result_q;

endmodule

// File: tb/tb_mul_iter_unit.sv
// Bench for mul_iter_unit: two configurations (32-bit full-length, 64-bit
// early-out) share stimulus; a transaction-level model predicts each cycle.
module tb_mul_iter_unit;
   import mul_iter_unit_pkg::*;

   logic        clk = 1'b0;
   logic        reset_n, start, kill, is_word_op;
   logic [1:0]  mul_op;
   logic [63:0] op_a, op_b;
   logic [31:0] res32;
   logic [63:0] res64;
   logic        busy32, busy64, rdy32, rdy64;

   int n_pass = 0;
   int n_total = 0;
   bit chk_en = 1'b0;

   int xl [2] = '{32, 64};
   int bpc[2] = '{2, 4};
   int eo [2] = '{0, 1};

   int          m_rem [2];
   logic [63:0] m_pend[2];
   logic [63:0] m_res [2];
   logic        m_rdy [2];

   always #5 clk = ~clk;

   mul_iter_unit #(.XLEN(32), .BITS_PER_CYCLE(2), .EARLY_OUT(1'b0)) dut32 (
      .clk(clk), .reset_n(reset_n), .start(start), .kill(kill), .mul_op(mul_op),
      .is_word_op(is_word_op), .operand_a(op_a[31:0]), .operand_b(op_b[31:0]),
      .result(res32), .busy(busy32), .ready(rdy32));

   mul_iter_unit #(.XLEN(64), .BITS_PER_CYCLE(4), .EARLY_OUT(1'b1)) dut64 (
      .clk(clk), .reset_n(reset_n), .start(start), .kill(kill), .mul_op(mul_op),
      .is_word_op(is_word_op), .operand_a(op_a), .operand_b(op_b),
      .result(res64), .busy(busy64), .ready(rdy64));

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   function automatic logic [63:0] wmask(int w);
      return (w == 32) ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
   endfunction

   // Reference product: two's-complement extension then one 128-bit multiply.
   function automatic logic [63:0] ref_mul(int x, logic [1:0] op, logic w,
                                           logic [63:0] a, logic [63:0] b);
      logic [127:0] ea, eb, u;
      logic sa, sb;
      if (x == 64 && w) begin
         u = {96'b0, a[31:0]} * {96'b0, b[31:0]};
         return {{32{u[31]}}, u[31:0]};
      end
      sa = (op == 2'b01) || (op == 2'b10);
      sb = (op == 2'b01);
      ea = {64'b0, a & wmask(x)};
      eb = {64'b0, b & wmask(x)};
      if (sa && ea[x-1]) ea = ea | ({128{1'b1}} << x);
      if (sb && eb[x-1]) eb = eb | ({128{1'b1}} << x);
      u = ea * eb;
      if (op == 2'b00) return u[63:0] & wmask(x);
      u = u >> x;
      return u[63:0] & wmask(x);
   endfunction

   // Compute cycles: full digit count, or significant multiplier digits with early-out.
   function automatic int ref_k(int d, logic [1:0] op, logic w, logic [63:0] b);
      int ow, bl, k;
      logic [63:0] m;
      ow = (xl[d] == 64 && w) ? 32 : xl[d];
      if (eo[d] == 0) return (ow + bpc[d] - 1) / bpc[d];
      m = b & wmask(ow);
      if (ow == xl[d] && op == 2'b01 && m[xl[d]-1]) m = (~m + 64'd1) & wmask(xl[d]);
      bl = 0;
      for (int i = 0; i < 64; i++) if (m[i]) bl = i + 1;
      k = (bl + bpc[d] - 1) / bpc[d];
      return (k < 1) ? 1 : k;
   endfunction

   // Model: remaining-busy-cycles timeline per configuration.
   always @(posedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (!reset_n) begin
            m_rem[d] <= 0; m_res[d] <= '0; m_rdy[d] <= 1'b0;
         end else if (kill) begin
            m_rem[d] <= 0; m_rdy[d] <= 1'b0;
         end else if (m_rem[d] == 0) begin
            m_rdy[d] <= 1'b0;
            if (start) begin
               m_rem[d]  <= ref_k(d, mul_op, is_word_op, op_b) + 1;
               m_pend[d] <= ref_mul(xl[d], mul_op, is_word_op, op_a, op_b);
            end
         end else if (m_rem[d] == 1) begin
            m_rem[d] <= 0; m_rdy[d] <= 1'b1; m_res[d] <= m_pend[d];
         end else begin
            m_rem[d] <= m_rem[d] - 1; m_rdy[d] <= 1'b0;
         end
      end
   end

   // Per-cycle comparison of all outputs against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         check("busy32",   {63'b0, busy32}, {63'b0, m_rem[0] != 0});
         check("ready32",  {63'b0, rdy32},  {63'b0, m_rdy[0]});
         check("result32", {32'b0, res32},  m_res[0] & wmask(32));
         check("busy64",   {63'b0, busy64}, {63'b0, m_rem[1] != 0});
         check("ready64",  {63'b0, rdy64},  {63'b0, m_rdy[1]});
         check("result64", res64,           m_res[1]);
      end
   end

   task automatic issue(input logic [1:0] op, input logic w, input logic [63:0] a, input logic [63:0] b);
      mul_op = op; is_word_op = w; op_a = a; op_b = b; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      op_a = {$urandom, $urandom}; op_b = {$urandom, $urandom};
      mul_op = 2'($urandom); is_word_op = 1'($urandom);
   endtask

   // Returns the cycle (counting the first post-accept cycle as 1) of the ready pulse, 0 on timeout.
   task automatic wait_ready(input int d, output int cyc, output int nbusy);
      cyc = 0; nbusy = 0;
      for (int c = 1; c <= 200; c++) begin
         @(negedge clk);
         if ((d == 0) ? rdy32 : rdy64) begin cyc = c; break; end
         if ((d == 0) ? busy32 : busy64) nbusy++;
      end
   endtask

   task automatic wait_idle();
      for (int c = 0; c < 300; c++) begin
         @(negedge clk);
         if (!busy32 && !busy64) break;
      end
      check("wait idle", {62'b0, busy32, busy64}, 64'd0);
   endtask

   function automatic logic [63:0] pick();
      case ($urandom % 6)
         0: return 64'd0;
         1: return 64'($urandom % 16);
         2: return '1;
         3: return 64'h8000_0000_8000_0000;
         default: return {$urandom, $urandom};
      endcase
   endfunction

   initial begin
      int cyc, nb, nr;
      reset_n = 1'b0; start = 1'b0; kill = 1'b0; mul_op = 2'b00; is_word_op = 1'b0;
      op_a = '0; op_b = '0;
      repeat (3) @(posedge clk);
      #1 reset_n = 1'b1; chk_en = 1'b1;
      @(negedge clk);
      check("reset result32", {32'b0, res32}, 64'd0);
      check("reset result64", res64, 64'd0);
      check("reset busy/ready", {60'b0, busy32, busy64, rdy32, rdy64}, 64'd0);

      issue(2'b00, 1'b0, 64'd7, 64'd6);
      wait_ready(0, cyc, nb);
      check("mul 7x6 ready cycle", 64'(cyc), 64'd18);
      check("mul 7x6 busy cycles", 64'(nb), 64'd17);
      check("mul 7x6 result", {32'b0, res32}, 64'h2A);
      check("model 7x6", m_res[0], 64'h2A);

      wait_idle();
      issue(2'b01, 1'b0, 64'hFFFF_FFFF, 64'hFFFF_FFFF);
      wait_ready(0, cyc, nb);
      check("mulh -1*-1", {32'b0, res32}, 64'h0);
      wait_idle();
      issue(2'b11, 1'b0, 64'hFFFF_FFFF, 64'hFFFF_FFFF);
      wait_ready(0, cyc, nb);
      check("mulhu ffffffff^2", {32'b0, res32}, 64'hFFFF_FFFE);
      check("model mulhu", m_res[0], 64'hFFFF_FFFE);
      wait_idle();
      issue(2'b10, 1'b0, 64'h8000_0000, 64'h2);
      wait_ready(0, cyc, nb);
      check("mulhsu 80000000*2", {32'b0, res32}, 64'hFFFF_FFFF);

      wait_idle();
      issue(2'b00, 1'b0, 64'h1234_5678, 64'd0);
      wait_ready(1, cyc, nb);
      check("early-out x*0 ready cycle", 64'(cyc), 64'd3);
      check("early-out x*0 result", res64, 64'd0);
      wait_idle();
      issue(2'b00, 1'b0, 64'd5, 64'd3);
      wait_ready(1, cyc, nb);
      check("early-out 5*3 ready cycle", 64'(cyc), 64'd3);
      check("early-out 5*3 result", res64, 64'hF);

      wait_idle();
      issue(2'b00, 1'b0, 64'hDEAD_BEEF, 64'h1234_5677);
      repeat (4) @(posedge clk);
      #1 kill = 1'b1;
      @(posedge clk);
      #1 kill = 1'b0;
      @(negedge clk);
      check("kill busy low", {63'b0, busy32}, 64'd0);
      nr = 0;
      repeat (20) begin @(negedge clk); if (rdy32) nr++; end
      check("kill no ready", 64'(nr), 64'd0);
      check("kill keeps result", {32'b0, res32}, 64'hF);
      issue(2'b00, 1'b0, 64'd2, 64'd3);
      wait_ready(0, cyc, nb);
      check("mul 2*3 after kill", {32'b0, res32}, 64'd6);

      wait_idle();
      issue(2'b00, 1'b1, 64'h0000_0000_7FFF_FFFF, 64'h2);
      @(posedge clk); #1;
      mul_op = 2'b01; op_a = 64'h1111; op_b = 64'h2222; start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      @(negedge clk);
      check("mulw ready", {63'b0, rdy64}, 64'd1);
      check("mulw result", res64, 64'hFFFF_FFFF_FFFF_FFFE);
      wait_idle();
      check("word ignored on rv32", {32'b0, res32}, 64'hFFFF_FFFE);

      issue(2'b10, 1'b0, 64'h1234_5678_9ABC_DEF0, '1);
      @(posedge clk); #1 reset_n = 1'b0;
      @(posedge clk); #1 reset_n = 1'b1;
      @(negedge clk);
      check("reset mid-op outputs32", {31'b0, busy32, rdy32, res32}, 64'd0);
      check("reset mid-op outputs64", {62'b0, busy64, rdy64} | res64, 64'd0);

      wait_idle();
      issue(2'b00, 1'b0, 64'd1000, 64'd1000);
      wait_ready(0, cyc, nb);
      check("b2b first result", {32'b0, res32}, 64'hF4240);
      issue(2'b11, 1'b0, 64'hFFFF_FFFF, 64'h0001_0000);
      wait_ready(0, cyc, nb);
      check("b2b second ready cycle", 64'(cyc), 64'd18);
      check("b2b second result", {32'b0, res32}, 64'h0000_FFFF);

      for (int i = 0; i < 1500; i++) begin
         @(posedge clk); #1;
         start      = ($urandom % 3) == 0;
         kill       = ($urandom % 40) == 0;
         reset_n    = ($urandom % 300) != 0;
         mul_op     = 2'($urandom);
         is_word_op = 1'($urandom);
         op_a       = pick();
         op_b       = pick();
      end
      @(posedge clk); #1;
      reset_n = 1'b1; kill = 1'b0; start = 1'b0;
      wait_idle();
      repeat (2) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/mul_iter_unit.md
MUL_ITER_UNIT -- requirements
Module: mul_iter_unit

Interface
REQ-001 Parameter XLEN, default `XLEN, datapath width (32 or 64).
REQ-002 Parameter BITS_PER_CYCLE, default 2, multiplier bits retired per COMPUTE cycle (1, 2, 4 or 8).
REQ-003 Parameter EARLY_OUT, default 1, enables termination once the remaining multiplier bits are all zero.
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 reset_n  input  1  synchronous active-low reset.
REQ-006 start  input  1  request; sampled only in IDLE.
REQ-007 kill  input  1  abort/flush of the current operation.
REQ-008 mul_op  input  2  00=MUL, 01=MULH, 10=MULHSU, 11=MULHU.
REQ-009 is_word_op  input  1  RV64 MULW; ignored when XLEN=32.
REQ-010 operand_a, operand_b  input  XLEN  multiplicand, multiplier.
REQ-011 result  output  XLEN  registered result; held until the next completion.
REQ-012 busy  output  1  combinational, high when state != IDLE.
REQ-013 ready  output  1  registered one-cycle completion pulse.

Function
REQ-014 States: IDLE, COMPUTE, DONE; 2-bit encoding.
REQ-015 IDLE to COMPUTE on start && !kill; operands, op and word flag captured at that edge.
REQ-016 Signed handling: a is signed for MULH/MULHSU, b is signed for MULH; magnitudes multiplied; result_negative = neg_a XOR neg_b.
REQ-017 Negation applies to the full 2*XLEN product before any field is selected.
REQ-018 When is_word_op=1 and XLEN=64, mul_op is ignored; the result is the low 32 bits of operand_a[31:0]*operand_b[31:0], sign-extended from bit 31.
REQ-019 op_width is 32 for word ops, XLEN otherwise.
REQ-020 Each COMPUTE cycle adds multiplicand*multiplier[BITS_PER_CYCLE-1:0] to product, shifts the multiplicand left by BITS_PER_CYCLE and shifts the multiplier right by BITS_PER_CYCLE.
REQ-021 Iteration count K = ceil(op_width/BITS_PER_CYCLE) when EARLY_OUT=0.
REQ-022 With EARLY_OUT=1, COMPUTE exits after the first step whose shifted multiplier is zero; K is at least 1; a multiplier of 0 gives K=1.
REQ-023 COMPUTE to DONE after the K-th step; DONE to IDLE unconditionally.
REQ-024 Result selection in DONE: MUL takes the low XLEN bits; the MULH variants take the high XLEN bits.
REQ-025 Timing: start is sampled at edge 0; COMPUTE occupies cycles 1..K; DONE is cycle K+1; ready=1 and result is valid in cycle K+2.
REQ-026 ready is low in every other cycle.
REQ-027 A start sampled in the ready cycle is accepted, giving back-to-back operations.
REQ-028 start while busy is ignored; the operation in flight is unaffected.
REQ-029 kill in any state forces IDLE at the next edge, suppresses ready and leaves result unchanged.
REQ-030 kill has priority over start in the same cycle.
REQ-031 kill in DONE suppresses that cycle's ready pulse and result update.
REQ-032 Operand inputs need not be held stable after acceptance.

Reset
REQ-033 When reset_n is low at an edge: state=IDLE, ready=0, result=0, and product, multiplicand, multiplier, counter and captured op are all zeroed.
REQ-034 Reset mid-operation discards the operation with no ready pulse.
REQ-035 Reset is synchronous only; there is no asynchronous clear path.

Structure
REQ-036 The mul_op encodings and the state encodings live in the shared core constants header used by the ALU/divider and are not redefined locally.
REQ-037 One sub-module, mul_step, is combinational: inputs are product, multiplicand and the multiplier digit; output is the next product. It is parameterised by XLEN and BITS_PER_CYCLE.
REQ-038 An elaboration-time check rejects any BITS_PER_CYCLE outside {1,2,4,8}.

Verification
REQ-039 XLEN=32, BPC=2, EARLY_OUT=0: MUL 7*6 -> result 0x0000002A, ready exactly at cycle 18, busy high for cycles 1..17.
REQ-040 MULH 0xFFFFFFFF*0xFFFFFFFF -> 0x00000000; MULHU with the same operands -> 0xFFFFFFFE; MULHSU 0x80000000*0x00000002 -> 0xFFFFFFFF.
REQ-041 EARLY_OUT=1: MUL 0x12345678*0 -> 0, ready at cycle 3; MUL 5*3 (BPC=2) -> 0x0000000F with K=1, ready at cycle 3.
REQ-042 kill asserted in COMPUTE cycle 5 -> no ready pulse, busy low next cycle, result keeps its prior value; a following MUL 2*3 -> 6.
REQ-043 XLEN=64: MULW 0x00000000_7FFFFFFF * 0x2 -> 0xFFFFFFFF_FFFFFFFE; start pulsed while busy leaves the in-flight result intact.
REQ-044 reset_n low in COMPUTE -> next cycle all outputs are 0 and state is IDLE; a back-to-back start in the ready cycle is accepted and completes correctly.
